// File: rtl/uart_word_rx.sv
// 8N1 UART receiver (optional even parity via UART_RX_PARITY_EN) that packs DATA_BYTES bytes
// into one AXI-Stream word, with glitch rejection, frame/parity/overrun/timeout reporting.
module uart_word_rx #(
  parameter int unsigned DATA_BYTES   = 8,
  parameter int unsigned TIMEOUT_BITS = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rxd,
  input  logic [15:0]             prescale,
  output logic [8*DATA_BYTES-1:0] m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    rx_busy,
  output logic                    frame_error,
  output logic                    parity_error,
  output logic                    overrun_error,
  output logic                    timeout_error
);

  localparam int unsigned WordW = 8 * DATA_BYTES;
  localparam int unsigned IdxW  = (DATA_BYTES > 1) ? $clog2(DATA_BYTES) : 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

  state_e            state_q;
  logic              rxd_s1, rxd_s2;
  logic [18:0]       timer_q;
  logic [15:0]       presc_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shreg_q;
  logic [IdxW-1:0]   byte_idx_q;
  logic [WordW-1:0]  asm_q;
  logic [18:0]       to_clk_q;
  logic [31:0]       to_bits_q;
`ifdef UART_RX_PARITY_EN
  logic              par_bad_q;
`endif

  logic [18:0]      half_load, full_load;
  logic             start_det, expire, stop_samp, frame_bad, par_ok, par_err, byte_ok;
  logic             last_byte, handshake, bit_tick, to_active, to_fire;
  logic [WordW-1:0] word_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_s1 <= 1'b1;
      rxd_s2 <= 1'b1;
    end else begin
      rxd_s1 <= rxd;
      rxd_s2 <= rxd_s1;
    end
  end

  always_comb begin
    half_load = {1'b0, prescale, 2'b00} - 19'd1;
    full_load = {presc_q, 3'b000} - 19'd1;
    start_det = (state_q == StIdle) && !rxd_s2 && (prescale != 16'd0);
    expire    = (timer_q == 19'd0);
    stop_samp = (state_q == StStop) && expire;
    frame_bad = stop_samp && !rxd_s2;
`ifdef UART_RX_PARITY_EN
    par_ok    = !par_bad_q;
`else
    par_ok    = 1'b1;
`endif
    // A bad stop bit masks a parity mismatch on the same byte.
    par_err   = stop_samp && rxd_s2 && !par_ok;
    byte_ok   = stop_samp && rxd_s2 && par_ok;
    last_byte = (byte_idx_q == IdxW'(DATA_BYTES - 1));
    handshake = m_axis_tvalid && m_axis_tready;
    word_next = asm_q;
    for (int unsigned i = 0; i < DATA_BYTES; i++) begin
      if (byte_idx_q == IdxW'(i)) word_next[8*i +: 8] = shreg_q;
    end
    bit_tick  = (to_clk_q == full_load);
    to_active = (TIMEOUT_BITS != 0) && (state_q == StIdle) && (byte_idx_q != '0) && !start_det;
    to_fire   = to_active && bit_tick && (to_bits_q == TIMEOUT_BITS - 1);
  end

  // Bit-level receive FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      timer_q   <= '0;
      presc_q   <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      rx_busy   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (start_det) begin
            state_q <= StStart;
            timer_q <= half_load;
            presc_q <= prescale;
            rx_busy <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_bad_q <= 1'b0;
`endif
          end
        end
        StStart: begin
          if (!expire) begin
            timer_q <= timer_q - 19'd1;
          end else if (!rxd_s2) begin
            state_q   <= StData;
            timer_q   <= full_load;
            bit_cnt_q <= '0;
          end else begin
            state_q <= StIdle;
            rx_busy <= 1'b0;
          end
        end
        StData: begin
          if (!expire) begin
            timer_q <= timer_q - 19'd1;
          end else begin
            shreg_q   <= {rxd_s2, shreg_q[7:1]};
            timer_q   <= full_load;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (!expire) begin
            timer_q <= timer_q - 19'd1;
          end else begin
            par_bad_q <= (rxd_s2 != ^shreg_q);
            timer_q   <= full_load;
            state_q   <= StStop;
          end
        end
`endif
        StStop: begin
          if (!expire) begin
            timer_q <= timer_q - 19'd1;
          end else begin
            state_q <= StIdle;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Byte packer, output register and inter-byte timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_idx_q    <= '0;
      asm_q         <= '0;
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      frame_error   <= 1'b0;
      overrun_error <= 1'b0;
      timeout_error <= 1'b0;
      to_clk_q      <= '0;
      to_bits_q     <= '0;
    end else begin
      frame_error   <= frame_bad;
      overrun_error <= 1'b0;
      timeout_error <= to_fire;
      if (handshake) m_axis_tvalid <= 1'b0;

      if (frame_bad || par_err) begin
        byte_idx_q <= '0;
      end else if (byte_ok) begin
        asm_q <= word_next;
        if (last_byte) begin
          byte_idx_q <= '0;
          if (!m_axis_tvalid || handshake) begin
            m_axis_tdata  <= word_next;
            m_axis_tvalid <= 1'b1;
          end else begin
            overrun_error <= 1'b1;
          end
        end else begin
          byte_idx_q <= byte_idx_q + IdxW'(1);
        end
      end else if (to_fire) begin
        byte_idx_q <= '0;
        asm_q      <= '0;
      end

      if (!to_active) begin
        to_clk_q  <= '0;
        to_bits_q <= '0;
      end else if (bit_tick) begin
        to_clk_q  <= '0;
        to_bits_q <= to_bits_q + 32'd1;
      end else begin
        to_clk_q <= to_clk_q + 19'd1;
      end
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) parity_error <= 1'b0;
    else      parity_error <= par_err;
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx: directed scenarios plus randomized bytes, checked against
// a byte-queue model of word assembly, error reporting and output hold.
module tb_uart_word_rx;

  localparam int DB      = 8;
  localparam int TIMEOUT = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxd;
  logic [15:0]   prescale;
  logic [63:0]   m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic          rx_busy, frame_error, parity_error, overrun_error, timeout_error;

  uart_word_rx #(.DATA_BYTES(DB), .TIMEOUT_BITS(TIMEOUT)) dut (
    .clk           (clk),
    .rst           (rst),
    .rxd           (rxd),
    .prescale      (prescale),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .rx_busy       (rx_busy),
    .frame_error   (frame_error),
    .parity_error  (parity_error),
    .overrun_error (overrun_error),
    .timeout_error (timeout_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Monitor: counts pulses / valid cycles and collects accepted words.
  logic [63:0] got_q[$];
  int n_fe = 0, n_pe = 0, n_oe = 0, n_te = 0, tv_cyc = 0;
  always @(negedge clk) begin
    if (m_axis_tvalid) tv_cyc++;
    if (m_axis_tvalid && m_axis_tready) got_q.push_back(m_axis_tdata);
    if (frame_error)   n_fe++;
    if (parity_error)  n_pe++;
    if (overrun_error) n_oe++;
    if (timeout_error) n_te++;
  end

  // Reference model: bytes queue into a word; errors clear it; a held word blocks the next one.
  logic [7:0]  m_bytes[$];
  logic [63:0] exp_words[$];
  logic [63:0] m_pend;
  bit          m_hold = 1'b0;
  int          m_fe = 0, m_pe = 0, m_oe = 0, m_te = 0;
  int          chk_idx = 0;

  task automatic mdl_byte(input logic [7:0] b, input int mode);
    logic [63:0] w;
    if (mode == 1) begin
      m_fe++;
      m_bytes.delete();
    end else if (mode == 2) begin
      m_pe++;
      m_bytes.delete();
    end else begin
      m_bytes.push_back(b);
      if (m_bytes.size() == DB) begin
        w = '0;
        for (int i = 0; i < DB; i++) w[8*i +: 8] = m_bytes[i];
        m_bytes.delete();
        if (m_axis_tready) exp_words.push_back(w);
        else if (m_hold) m_oe++;
        else begin
          m_hold = 1'b1;
          m_pend = w;
        end
      end
    end
  endtask

  task automatic mdl_idle(input int bits);
    if (bits >= TIMEOUT && m_bytes.size() != 0) begin
      m_te++;
      m_bytes.delete();
    end
  endtask

  task automatic set_ready();
    m_axis_tready = 1'b1;
    if (m_hold) begin
      exp_words.push_back(m_pend);
      m_hold = 1'b0;
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // mode: 0 good, 1 stop bit 0, 2 wrong parity bit
  task automatic send_frame(input logic [7:0] b, input int mode);
    int bp;
    bp = 8 * int'(prescale);
    rxd = 1'b0;
    wait_clks(bp);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(bp);
    end
`ifdef UART_RX_PARITY_EN
    rxd = (^b) ^ (mode == 2);
    wait_clks(bp);
`endif
    rxd = (mode != 1);
    wait_clks(bp);
    rxd = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int mode, input int gap_bits);
    send_frame(b, mode);
    mdl_byte(b, mode);
    wait_clks(gap_bits * 8 * int'(prescale));
    mdl_idle(gap_bits);
  endtask

  task automatic send_word(input logic [7:0] base);
    for (int i = 0; i < DB; i++) send_byte(8'(base + 8'(i)), 0, 0);
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, " word count"}, 64'(got_q.size()), 64'(exp_words.size()));
    for (int i = chk_idx; i < exp_words.size() && i < got_q.size(); i++)
      check_eq($sformatf("%s word%0d", tag, i), got_q[i], exp_words[i]);
    chk_idx = exp_words.size();
    check_eq({tag, " frame_error count"},   64'(n_fe), 64'(m_fe));
    check_eq({tag, " parity_error count"},  64'(n_pe), 64'(m_pe));
    check_eq({tag, " overrun_error count"}, 64'(n_oe), 64'(m_oe));
    check_eq({tag, " timeout_error count"}, 64'(n_te), 64'(m_te));
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, " tvalid"}, 64'(m_axis_tvalid), 64'd0);
    check_eq({tag, " tdata"},  m_axis_tdata, 64'd0);
    check_eq({tag, " rx_busy"}, 64'(rx_busy), 64'd0);
    check_eq({tag, " err pulses"},
             64'({frame_error, parity_error, overrun_error, timeout_error}), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tv0, tgt, n, mode;
    rst = 1'b0;
    rxd = 1'b1;
    prescale = 16'd2;
    m_axis_tready = 1'b1;
    wait_clks(3);
    check_quiet("reset");
    rst = 1'b1;
    wait_clks(20);

    // Basic word, tvalid exactly one cycle.
    tv0 = tv_cyc;
    send_word(8'h01);
    wait_clks(4);
    check_all("t1");
    check_eq("t1 tvalid cycles", 64'(tv_cyc - tv0), 64'd1);
    check_eq("t1 expected word", exp_words[0], 64'h0807060504030201);

    // Frame error resync (and parity error when enabled).
    send_byte(8'h01, 0, 0);
    send_byte(8'h02, 0, 0);
    send_byte(8'h03, 1, 2);
    send_word(8'h11);
`ifdef UART_RX_PARITY_EN
    send_byte(8'h01, 0, 0);
    send_byte(8'hA5, 2, 1);
    send_word(8'h11);
`endif
    wait_clks(4);
    check_all("t2");

    // Overrun with sink stalled.
    m_axis_tready = 1'b0;
    send_word(8'h01);
    send_word(8'h21);
    wait_clks(4);
    check_all("t3 stalled");
    check_eq("t3 tvalid held", 64'(m_axis_tvalid), 64'd1);
    check_eq("t3 tdata held", m_axis_tdata, 64'h0807060504030201);
    set_ready();
    wait_clks(3);
    check_eq("t3 tvalid after drain", 64'(m_axis_tvalid), 64'd0);
    check_all("t3 drained");

    // Inter-byte timeout.
    send_byte(8'hAA, 0, 0);
    send_byte(8'hBB, 0, 0);
    send_byte(8'hCC, 0, 40);
    check_all("t4 timeout");
    send_word(8'h01);
    wait_clks(4);
    check_all("t4");

    // Start glitch, then reset in the middle of a data bit.
    rxd = 1'b0;
    wait_clks(3);
    rxd = 1'b1;
    wait_clks(24);
    check_eq("t5 busy after glitch", 64'(rx_busy), 64'd0);
    check_all("t5 glitch");
    rxd = 1'b0;
    wait_clks(16);
    rxd = 1'b1;
    wait_clks(16);
    rxd = 1'b0;
    wait_clks(8);
    check_eq("t5 busy mid frame", 64'(rx_busy), 64'd1);
    rst = 1'b0;
    #1;
    check_quiet("t5 reset");
    rxd = 1'b1;
    wait_clks(3);
    rst = 1'b1;
    wait_clks(32);
    send_word(8'h01);
    wait_clks(4);
    check_all("t5 after reset");

    // Randomized bytes, gaps, prescale and occasional bad stop bits.
    for (int w = 0; w < 3; w++) begin
      prescale = 16'($urandom_range(2, 3));
      tgt = exp_words.size() + 1;
      n = 0;
      while (exp_words.size() < tgt && n < 40) begin
        mode = ($urandom_range(0, 7) == 0) ? 1 : 0;
        send_byte(8'($urandom), mode, (mode == 1) ? 2 : int'($urandom_range(0, 2)));
        n++;
      end
      wait_clks(4);
      check_all($sformatf("rand%0d", w));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
